tile_renderer: RTL
==================

Name: tile_renderer

Overview:
- Pixel-generation stage that sits directly downstream of vga_controller and produces the red/green/blue buses for the VGA DAC.
- Consumes the 25 MHz pixel clock, the hCount/vCount/bright/hSync/vSync timing from the controller, and external nametable and pattern RAMs.
- Renders a 320x240 logical screen at 2x scale: 8x8 logical tiles, 2 bpp, four 4-colour palettes, colours in RGB332.
- Delays the sync and blank signals so they stay aligned with the pixel data.

Parameters:
- TILE_COLS, 40, tiles per row; also the multiplier in the nametable address.
- TILE_ROWS, 30, tile rows per frame.
- SYNC_IDLE, 1'b1, inactive level of hsync_out/vsync_out; sync is active-low.

Ports:
- clk  in  1  25 MHz pixel clock.
- reset  in  1  Reset, synchronous, active-low.
- hcount  in  10  Horizontal pixel count from vga_controller.
- vcount  in  10  Vertical line count from vga_controller.
- bright  in  1  Active-video flag from vga_controller.
- hsync_in  in  1  hSync from vga_controller.
- vsync_in  in  1  vSync from vga_controller.
- nt_addr  out  11  Nametable RAM read address.
- nt_data  in  10  Nametable entry: [7:0] tile index, [9:8] palette select. Valid one clock after nt_addr.
- pt_addr  out  11  Pattern RAM read address, {tile[7:0], fine_y[2:0]}.
- pt_data  in  16  Pattern row: [15:8] plane 1, [7:0] plane 0, MSB is the leftmost pixel. Valid one clock after pt_addr.
- pal_we  in  1  Palette write strobe.
- pal_addr  in  4  Palette entry to write.
- pal_wdata  in  8  RGB332 colour to write.
- red  out  8  Expanded red channel.
- green  out  8  Expanded green channel.
- blue  out  8  Expanded blue channel.
- hsync_out  out  1  hsync_in delayed by 4 clocks.
- vsync_out  out  1  vsync_in delayed by 4 clocks.
- blank_n_out  out  1  bright delayed by 4 clocks; drives VGA_BLANK_N.

Behaviour:
- Reset (while reset==0 at a clk edge):
  - All pipeline registers cleared; red/green/blue=0, blank_n_out=0.
  - hsync_out=vsync_out=SYNC_IDLE; nt_addr=pt_addr=0.
  - All 16 palette entries set to 8'h00.
  - Reset asserted mid-frame flushes the pipeline. The first valid output appears 4 clocks after the first non-reset edge.
- S0 (edge 1): register hcount, vcount, bright, hsync_in, vsync_in.
  - col=hcount[9:4], row=vcount[8:4].
  - nt_addr = row*40 + col, computed combinationally from the S0 registers as (row<<5)+(row<<3)+col; maximum 1199.
  - nt_addr is forced to 0 when S0 bright==0.
- S1 (edge 2): nt_data is valid.
  - pt_addr = {nt_data[7:0], vcount_s0[3:1]}, driven combinationally from nt_data and S1 registers.
  - Register pal_sel=nt_data[9:8] and fine_x=hcount_s0[3:1].
- S2 (edge 3): pt_data is valid.
  - idx = {pt_data[15-fine_x], pt_data[7-fine_x]}.
  - pal_rd = (idx==0) ? 4'd0 : {pal_sel, idx}. Index 0 always selects the shared backdrop entry 0.
- S3 (edge 4): registered palette read and expansion.
  - Colour c=pal[pal_rd].
  - red={c[7:5],c[7:5],c[7:6]}; green={c[4:2],c[4:2],c[4:3]}; blue={c[1:0],c[1:0],c[1:0],c[1:0]}.
  - If delayed bright==0, red/green/blue=0.
- Latency: exactly 4 clocks from every input sample to red/green/blue/hsync_out/vsync_out/blank_n_out. The side-band 4-deep shift registers reset to SYNC_IDLE/SYNC_IDLE/0.
- Palette writes:
  - Synchronous on clk when pal_we=1; accepted any time.
  - Same-cycle write and S3 read of the same entry returns the old value; the new value is visible from the next cycle.
  - pal_we is ignored during reset.
- Line 0 of each tile row uses vcount[3:1]=0. Odd/even scaled pixels repeat the same logical pixel.

Decomposition:
- Package tile_pkg:
  - TILE_COLS, TILE_ROWS, PIPE_LAT=4.
  - RGB332 expand function.
  - Field slices for nt_data and pt_data.
- Sub-module palette_ram: 16x8 register file, one synchronous write port, one registered read port, synchronous active-low reset to zero.

Test Plan:
- Reset: hold reset=0 for 3 clocks with random inputs -> red=green=blue=0, hsync_out=vsync_out=1, blank_n_out=0; reading any entry after release -> 0.
- Latency: drive hsync_in low for cycles 10..105 -> hsync_out low exactly for cycles 14..109; same check for vsync_in and bright.
- Address map: hcount=37, vcount=100, bright=1 -> nt_addr=242 after edge 1. hcount=639, vcount=479 -> 1199. bright=0 -> 0.
- Pixel path:
  - Setup: pal[10]=8'hE0; nt_data=10'h205; pt_data=16'h8000; hcount=0, bright=1.
  - Expect pt_addr={8'h05,fine_y}.
  - Expect red=8'hFF, green=0, blue=0 at edge 4.
  - hcount=2 (same tile) -> idx 0 -> pal[0].
- Backdrop: pal[0]=8'h03, pal[12]=8'hFF, nt_data palette select 3, pt_data=0 -> blue=8'hFF, red=green=0.
- Write collision: pal_we with pal_addr=10, pal_wdata=8'h1C in the same cycle S3 reads entry 10 (old 8'hE0) -> that output red=8'hFF. Next pixel reading entry 10 -> green=8'hFF, red=0.

Source files
------------

// File: rtl/tile_pkg.sv
// Shared constants, bus payload layouts and colour helpers for the tile renderer.
package tile_pkg;

    localparam int unsigned TILE_COLS = 40;
    localparam int unsigned TILE_ROWS = 30;
    localparam int unsigned PIPE_LAT  = 4;
    localparam logic        SYNC_IDLE = 1'b1;

    localparam int unsigned CNT_W     = 10;
    localparam int unsigned NT_AW     = 11;
    localparam int unsigned NT_DW     = 10;
    localparam int unsigned PT_AW     = 11;
    localparam int unsigned PT_DW     = 16;
    localparam int unsigned PAL_AW    = 4;
    localparam int unsigned PAL_DEPTH = 16;
    localparam int unsigned COLOR_W   = 8;
    localparam int unsigned COL_W     = $clog2(TILE_COLS);
    localparam int unsigned ROW_W     = $clog2(TILE_ROWS);

    // Nametable entry: palette select above the tile index.
    typedef struct packed {
        logic [1:0] pal_sel;
        logic [7:0] tile;
    } nt_entry_t;

    // Pattern row: plane 1 in the upper byte, MSB is the leftmost pixel.
    typedef struct packed {
        logic [7:0] plane1;
        logic [7:0] plane0;
    } pt_row_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb888_t;

    // RGB332 to RGB888 by bit replication so full-scale maps to 8'hFF.
    function automatic rgb888_t rgb332_expand(input logic [7:0] c);
        rgb888_t o;
        o.red   = {c[7:5], c[7:5], c[7:6]};
        o.green = {c[4:2], c[4:2], c[4:3]};
        o.blue  = {c[1:0], c[1:0], c[1:0], c[1:0]};
        return o;
    endfunction

endpackage

// File: rtl/palette_ram.sv
// 16-entry RGB332 palette: one synchronous write port, one registered read port.
module palette_ram
    import tile_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               we,
    input  logic [PAL_AW-1:0]  waddr,
    input  logic [COLOR_W-1:0] wdata,
    input  logic [PAL_AW-1:0]  rd_addr,
    input  logic               rd_clr,
    output logic [COLOR_W-1:0] rd_data
);

    logic [COLOR_W-1:0] mem [PAL_DEPTH];

    // Write and read share an edge, so a same-entry read returns the old colour.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(PAL_DEPTH); i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (we) begin
                mem[waddr] <= wdata;
            end
            rd_data <= rd_clr ? '0 : mem[rd_addr];
        end
    end

endmodule

// File: rtl/tile_renderer.sv
// Four-stage tile/pattern/palette pixel pipeline with matching sync and blank delay.
module tile_renderer
    import tile_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   hcount,
    input  logic [CNT_W-1:0]   vcount,
    input  logic               bright,
    input  logic               hsync_in,
    input  logic               vsync_in,
    output logic [NT_AW-1:0]   nt_addr,
    input  logic [NT_DW-1:0]   nt_data,
    output logic [PT_AW-1:0]   pt_addr,
    input  logic [PT_DW-1:0]   pt_data,
    input  logic               pal_we,
    input  logic [PAL_AW-1:0]  pal_addr,
    input  logic [COLOR_W-1:0] pal_wdata,
    output logic [7:0]         red,
    output logic [7:0]         green,
    output logic [7:0]         blue,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic               blank_n_out
);

    logic [PIPE_LAT-1:0] br_pipe;
    logic [PIPE_LAT-1:0] hs_pipe;
    logic [PIPE_LAT-1:0] vs_pipe;

    logic [COL_W-1:0]    s0_col;
    logic [ROW_W-1:0]    s0_row;
    logic [2:0]          s0_fx;
    logic [2:0]          s0_fy;
    logic [2:0]          s1_fx;
    logic [2:0]          s1_fy;
    logic [2:0]          s2_fx;
    logic [1:0]          s2_pal;

    nt_entry_t           nt_ent;
    pt_row_t             pt_row;
    logic [1:0]          pix_idx;
    logic [PAL_AW-1:0]   pal_rd;
    logic                pal_clr;
    logic [COLOR_W-1:0]  pal_color;
    rgb888_t             rgb;

    // Pixel-count LSB and the top/bottom line-count bits do not select anything.
    logic                unused_bits;
    assign unused_bits = &{1'b0, hcount[0], vcount[CNT_W-1], vcount[0]};

    assign nt_ent = nt_entry_t'(nt_data);
    assign pt_row = pt_row_t'(pt_data);

    // S0: capture tile coordinates and fine offsets at 2x scale.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s0_col <= '0;
            s0_row <= '0;
            s0_fx  <= '0;
            s0_fy  <= '0;
        end else begin
            s0_col <= hcount[4 +: COL_W];
            s0_row <= vcount[4 +: ROW_W];
            s0_fx  <= hcount[3:1];
            s0_fy  <= vcount[3:1];
        end
    end

    // S1/S2: carry fine offsets forward and latch the palette select from the nametable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_fx  <= '0;
            s1_fy  <= '0;
            s2_fx  <= '0;
            s2_pal <= '0;
        end else begin
            s1_fx  <= s0_fx;
            s1_fy  <= s0_fy;
            s2_fx  <= s1_fx;
            s2_pal <= nt_ent.pal_sel;
        end
    end

    // Side-band shift registers, one tap per pipeline stage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            br_pipe <= '0;
            hs_pipe <= {PIPE_LAT{SYNC_IDLE}};
            vs_pipe <= {PIPE_LAT{SYNC_IDLE}};
        end else begin
            br_pipe <= {br_pipe[PIPE_LAT-2:0], bright};
            hs_pipe <= {hs_pipe[PIPE_LAT-2:0], hsync_in};
            vs_pipe <= {vs_pipe[PIPE_LAT-2:0], vsync_in};
        end
    end

    // row*40 reduces to (row<<5)+(row<<3); blanked fetches park on entry 0.
    assign nt_addr = br_pipe[0]
                   ? (NT_AW'(s0_row) * NT_AW'(TILE_COLS)) + NT_AW'(s0_col)
                   : '0;

    // Pattern row for the fetched tile; held at 0 while reset is asserted.
    assign pt_addr = reset ? {nt_ent.tile, s1_fy} : '0;

    // Two-bit colour index; index 0 is always the shared backdrop entry.
    assign pix_idx = {pt_row.plane1[3'd7 - s2_fx], pt_row.plane0[3'd7 - s2_fx]};
    assign pal_rd  = (pix_idx == 2'd0) ? '0 : {s2_pal, pix_idx};
    assign pal_clr = ~br_pipe[PIPE_LAT-2];

    palette_ram u_palette_ram (
        .clk     (clk),
        .reset   (reset),
        .we      (pal_we),
        .waddr   (pal_addr),
        .wdata   (pal_wdata),
        .rd_addr (pal_rd),
        .rd_clr  (pal_clr),
        .rd_data (pal_color)
    );

    // Expansion is pure bit replication of the registered palette colour.
    assign rgb         = rgb332_expand(pal_color);
    assign red         = rgb.red;
    assign green       = rgb.green;
    assign blue        = rgb.blue;
    assign hsync_out   = hs_pipe[PIPE_LAT-1];
    assign vsync_out   = vs_pipe[PIPE_LAT-1];
    assign blank_n_out = br_pipe[PIPE_LAT-1];

endmodule
